// File: rtl/pipe_skid_stage.sv
// Two-entry skid-buffered pipeline stage: registered valid/ready on both sides,
// synchronous flush for branch redirect, and a saturating stall-cycle counter.
module pipe_skid_stage #(
  parameter int unsigned       WIDTH      = 64,
  parameter logic [WIDTH-1:0]  RESET_DATA = '0,
  parameter int unsigned       CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     main_q, main_d;
  logic [WIDTH-1:0]     skid_q, skid_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_xfer, out_xfer;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;
    in_xfer     = in_valid & in_ready_q;
    out_xfer    = out_valid_q & out_ready;

    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_DATA;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_d = in_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = in_data;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain can happen
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    if (!flush && out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end

    // Handshake outputs are decoded from the next state so they leave flops directly
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      main_q      <= RESET_DATA;
      skid_q      <= '0;
      stall_cnt_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_cnt_q;

endmodule
